// File: rtl/handshake_tx.sv
// Transmit end of the valid/ready stream: a DEPTH-entry circular FIFO feeding a
// registered output slice, with every PKT_LEN-th beat marked by LAST_DOWN.
module handshake_tx #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int PKT_LEN = 4
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         WR_EN,
   input  logic [WIDTH-1:0]             WR_DATA,
   output logic                         FULL,
   output logic [$clog2(DEPTH+1)-1:0]   COUNT,
   output logic                         OVERFLOW,
   output logic                         VALID_DOWN,
   input  logic                         READY_DOWN,
   output logic [WIDTH-1:0]             DATA_DOWN,
   output logic                         LAST_DOWN
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PKT_W-1:0] pkt_cnt;

   logic             fifo_empty;
   logic             wr_accept;
   logic             load_en;
   logic             xfer;
   logic             pkt_last;
   logic [CNT_W-1:0] count_next;

   // NOTE: every signal written here gets a value before any branch, so no latch can form.
   always_comb begin
      fifo_empty = (COUNT == '0);
      wr_accept  = WR_EN && !FULL;
      // Output slice refills when empty or when its current beat leaves this edge;
      // READY_DOWN only gates the load, never VALID_DOWN directly.
      load_en    = !fifo_empty && (!VALID_DOWN || READY_DOWN);
      xfer       = VALID_DOWN && READY_DOWN;
      pkt_last   = (pkt_cnt == PKT_W'(PKT_LEN - 1));
      count_next = COUNT + CNT_W'(wr_accept) - CNT_W'(load_en);
   end

   // NOTE: the storage array carries no reset; its contents are only read behind rd_ptr/COUNT.
   always_ff @(posedge CLK) begin
      if (wr_accept) begin
         mem[wr_ptr] <= WR_DATA;
      end
   end

   // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pkt_cnt    <= '0;
         COUNT      <= '0;
         FULL       <= 1'b0;
         OVERFLOW   <= 1'b0;
         VALID_DOWN <= 1'b0;
         DATA_DOWN  <= '0;
         LAST_DOWN  <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (WR_EN && FULL) begin
            OVERFLOW <= 1'b1;
         end

         COUNT <= count_next;
         FULL  <= (count_next == CNT_W'(DEPTH));

         if (load_en) begin
            rd_ptr     <= rd_ptr + PTR_W'(1);
            VALID_DOWN <= 1'b1;
            DATA_DOWN  <= mem[rd_ptr];
            LAST_DOWN  <= pkt_last;
            pkt_cnt    <= pkt_last ? '0 : pkt_cnt + PKT_W'(1);
         end else if (xfer) begin
            VALID_DOWN <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_handshake_tx.sv
// Randomised scoreboard bench for handshake_tx: a queue-based model predicts
// beats and occupancy, a negedge monitor compares every presented beat.
module tb_handshake_tx;

   localparam int WIDTH   = 8;
   localparam int DEPTH   = 4;
   localparam int PKT_LEN = 4;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             last;
   } beat_t;

   logic             CLK;
   logic             RESET;
   logic             WR_EN;
   logic [WIDTH-1:0] WR_DATA;
   logic             FULL;
   logic [2:0]       COUNT;
   logic             OVERFLOW;
   logic             VALID_DOWN;
   logic             READY_DOWN;
   logic [WIDTH-1:0] DATA_DOWN;
   logic             LAST_DOWN;

   handshake_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .WR_EN      (WR_EN),
      .WR_DATA    (WR_DATA),
      .FULL       (FULL),
      .COUNT      (COUNT),
      .OVERFLOW   (OVERFLOW),
      .VALID_DOWN (VALID_DOWN),
      .READY_DOWN (READY_DOWN),
      .DATA_DOWN  (DATA_DOWN),
      .LAST_DOWN  (LAST_DOWN)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int checks = 0;
   int errors = 0;

   // Reference model: the FIFO as a plain queue plus the output slot.
   logic [WIDTH-1:0] m_fifo [$];
   bit               m_valid = 1'b0;
   int               m_loads = 0;
   bit               m_ovf   = 1'b0;
   beat_t            exp_q   [$];
   beat_t            rx_log  [$];
   logic [WIDTH-1:0] acc_log [$];

   bit               mon_on = 1'b0;
   logic             prev_valid, prev_ready, prev_rst, prev_last;
   logic [WIDTH-1:0] prev_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit rst, input bit wr, input logic [WIDTH-1:0] d, input bit rdy);
      bit    full_pre;
      bit    load;
      beat_t b;
      if (rst) begin
         m_fifo.delete();
         exp_q.delete();
         m_valid = 1'b0;
         m_loads = 0;
         m_ovf   = 1'b0;
         return;
      end
      full_pre = (m_fifo.size() == DEPTH);
      load     = (m_fifo.size() != 0) && (!m_valid || rdy);
      if (load) begin
         b.data  = m_fifo.pop_front();
         b.last  = ((m_loads % PKT_LEN) == PKT_LEN - 1);
         m_loads++;
         m_valid = 1'b1;
         exp_q.push_back(b);
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      if (wr) begin
         if (full_pre) begin
            m_ovf = 1'b1;
         end else begin
            m_fifo.push_back(d);
            acc_log.push_back(d);
         end
      end
   endtask

   task automatic step(input bit rst, input bit wr, input logic [WIDTH-1:0] d, input bit rdy);
      RESET      = rst;
      WR_EN      = wr;
      WR_DATA    = d;
      READY_DOWN = rdy;
      @(posedge CLK);
      model_edge(rst, wr, d, rdy);
      #1;
   endtask

   task automatic drain(input int n);
      repeat (n) step(1'b0, 1'b0, '0, 1'b1);
   endtask

   // Monitor: compares occupancy every cycle and pops the scoreboard on each transfer.
   always @(negedge CLK) begin
      if (mon_on) begin
         beat_t b;
         check("valid", VALID_DOWN, m_valid);
         check("count", COUNT, m_fifo.size());
         check("full", FULL, m_fifo.size() == DEPTH);
         check("overflow", OVERFLOW, m_ovf);
         check("count_bound", COUNT <= DEPTH, 1);
         if (prev_valid && !prev_ready && !prev_rst) begin
            check("stall_valid", VALID_DOWN, 1);
            check("stall_data", DATA_DOWN, prev_data);
            check("stall_last", LAST_DOWN, prev_last);
         end
         if (VALID_DOWN && READY_DOWN && !RESET) begin
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               b = exp_q.pop_front();
               check("beat_data", DATA_DOWN, b.data);
               check("beat_last", LAST_DOWN, b.last);
            end
            b.data = DATA_DOWN;
            b.last = LAST_DOWN;
            rx_log.push_back(b);
         end
      end
      prev_valid = VALID_DOWN;
      prev_ready = READY_DOWN;
      prev_rst   = RESET;
      prev_data  = DATA_DOWN;
      prev_last  = LAST_DOWN;
   end

   initial begin
      int n;
      bit wr;
      RESET      = 1'b1;
      WR_EN      = 1'b0;
      WR_DATA    = '0;
      READY_DOWN = 1'b0;

      // Reset with traffic applied
      step(1'b1, 1'b1, 8'h55, 1'b1);
      step(1'b1, 1'b1, 8'h55, 1'b1);
      check("rst_valid", VALID_DOWN, 0);
      check("rst_data", DATA_DOWN, 0);
      check("rst_last", LAST_DOWN, 0);
      check("rst_count", COUNT, 0);
      check("rst_full", FULL, 0);
      check("rst_overflow", OVERFLOW, 0);
      mon_on = 1'b1;

      // Single word latency
      step(1'b0, 1'b1, 8'hA5, 1'b1);
      check("lat_valid_e0", VALID_DOWN, 0);
      check("lat_count_e0", COUNT, 1);
      step(1'b0, 1'b0, '0, 1'b1);
      check("lat_valid_e1", VALID_DOWN, 1);
      check("lat_data_e1", DATA_DOWN, 8'hA5);
      step(1'b0, 1'b0, '0, 1'b1);
      check("lat_valid_e2", VALID_DOWN, 0);

      // Stall hold and overflow
      for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
      check("stall_hold_valid", VALID_DOWN, 1);
      check("stall_hold_data", DATA_DOWN, 8'h01);
      check("stall_count4", COUNT, 4);
      check("stall_full", FULL, 1);
      check("stall_no_ovf", OVERFLOW, 0);
      step(1'b0, 1'b1, 8'h06, 1'b0);
      check("ovf_set", OVERFLOW, 1);
      check("ovf_count", COUNT, 4);
      rx_log.delete();
      drain(8);
      check("stall_rx_n", rx_log.size(), 5);
      for (int i = 0; i < rx_log.size() && i < 5; i++) check("stall_rx_order", rx_log[i].data, i + 1);

      // Packet marking from a fresh packet counter
      step(1'b1, 1'b0, '0, 1'b1);
      rx_log.delete();
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b1);
      drain(4);
      check("pkt_rx_n", rx_log.size(), 8);
      for (int i = 0; i < rx_log.size() && i < 8; i++) begin
         check("pkt_data", rx_log[i].data, 8'h10 + i);
         check("pkt_last", rx_log[i].last, (i == 3) || (i == 7));
      end

      // Random back-pressure, payloads 0..199
      rx_log.delete();
      acc_log.delete();
      n = 0;
      while (n < 200) begin
         wr = ($urandom_range(0, 3) != 0);
         step(1'b0, wr, 8'(n), 1'($urandom_range(0, 1)));
         if (wr) n++;
      end
      drain(10);
      check("rand_rx_n", rx_log.size(), acc_log.size());
      for (int i = 0; i < rx_log.size() && i < acc_log.size(); i++) check("rand_order", rx_log[i].data, acc_log[i]);

      // Reset in the middle of a stall
      for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
      step(1'b1, 1'b1, 8'h99, 1'b1);
      check("mid_rst_valid", VALID_DOWN, 0);
      check("mid_rst_count", COUNT, 0);
      check("mid_rst_ovf", OVERFLOW, 0);
      rx_log.delete();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b1);
      drain(4);
      check("mid_rx_n", rx_log.size(), 4);
      for (int i = 0; i < rx_log.size() && i < 4; i++) begin
         check("mid_data", rx_log[i].data, 8'h40 + i);
         check("mid_last", rx_log[i].last, i == 3);
      end

      check("sb_drained", exp_q.size(), 0);
      mon_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
